// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the FSM state enum, default cycle counts and counter sizing.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT         = 3'd0,
    WAIT_LOCK      = 3'd1,
    STABLE         = 3'd2,
    RELEASE_PERIPH = 3'd3,
    RUN            = 3'd4
  } state_e;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int DEF_DEBOUNCE_CYCLES    = 65536;

  // Bits needed to count 0 .. max(a,b,c)-1.
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_debounce.sv
// Multi-flop synchroniser with optional debounce filter.
// Ports: clk_i, rst_i (sync, active-high), async_i, level_o (filtered).
module sync_debounce
  import reset_seq_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 0,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass

    assign level_o = sync_s;

  end else begin : g_debounce

    localparam int DW = cnt_width(DEBOUNCE_CYCLES, 1, 1);

    logic          level_q;
    logic          level_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        level_q <= RST_VAL;
        cnt_q   <= '0;
      end else begin
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end

    // Count consecutive samples at the opposite level;
    // any sample matching the held level restarts the count.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync_s != level_q) begin
        if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          level_d = sync_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign level_o = level_q;

  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Ordered reset release after PLL lock, with lock-loss tracking.
// Ports: clock, reset, pll_lock, ext_rst_n in; periph_reset,
// core_reset, ready, lock_lost, lock_loss_count[7:0] out.
module pll_reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       ext_rst_n,
  output logic       periph_reset,
  output logic       core_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lock_loss_count
);

  localparam int CW = cnt_width(
    LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES, DEBOUNCE_CYCLES);

  localparam logic [CW-1:0] LAST_STABLE =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LAST_HOLD =
    CW'(RESET_HOLD_CYCLES - 1);

  logic lock_s;
  logic btn_level;
  logic btn_pressed;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (0),
    .RST_VAL         (1'b0)
  ) u_lock_sync (
    .clk_i   (clock),
    .rst_i   (reset),
    .async_i (pll_lock),
    .level_o (lock_s)
  );

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_VAL         (1'b1)
  ) u_btn_sync (
    .clk_i   (clock),
    .rst_i   (reset),
    .async_i (ext_rst_n),
    .level_o (btn_level)
  );

  assign btn_pressed = ~btn_level;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          loss_event;

  logic       periph_q, periph_d;
  logic       core_q, core_d;
  logic       ready_q, ready_d;
  logic       lost_q, lost_d;
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ASSERT;
      cnt_q      <= '0;
      periph_q   <= 1'b1;
      core_q     <= 1'b1;
      ready_q    <= 1'b0;
      lost_q     <= 1'b0;
      loss_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      periph_q   <= periph_d;
      core_q     <= core_d;
      ready_q    <= ready_d;
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  // Button held in WAIT_LOCK just parks there; bouncing
  // back through ASSERT would gain nothing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    unique case (state_q)
      ASSERT: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      WAIT_LOCK: begin
        if (lock_s && !btn_pressed) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (btn_pressed) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LAST_STABLE) begin
          state_d = RELEASE_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE_PERIPH: begin
        if (!lock_s || btn_pressed) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end else if (cnt_q == LAST_HOLD) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // Lock loss outranks the button so it is always logged.
        if (!lock_s) begin
          state_d    = ASSERT;
          loss_event = 1'b1;
        end else if (btn_pressed) begin
          state_d = ASSERT;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they change on the
  // same edge as the transition.
  always_comb begin
    periph_d   = !(state_d == RELEASE_PERIPH ||
                   state_d == RUN);
    core_d     = (state_d != RUN);
    ready_d    = (state_d == RUN);
    lost_d     = lost_q | loss_event;
    loss_cnt_d = loss_cnt_q;
    if (loss_event && loss_cnt_q != 8'hFF) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  assign periph_reset    = periph_q;
  assign core_reset      = core_q;
  assign ready           = ready_q;
  assign lock_lost       = lost_q;
  assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer.
// Stimulus queues timed output events; a monitor checks them.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       ext_rst_n = 1'b1;
  logic       periph_reset;
  logic       core_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_loss_count;

  pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .RESET_HOLD_CYCLES  (4),
    .DEBOUNCE_CYCLES    (4)
  ) dut (
    .clock           (clk),
    .reset           (reset),
    .pll_lock        (pll_lock),
    .ext_rst_n       (ext_rst_n),
    .periph_reset    (periph_reset),
    .core_reset      (core_reset),
    .ready           (ready),
    .lock_lost       (lock_lost),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [11:0] val;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       m_ll = 1'b0;
  logic [7:0] m_cnt = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any output change must match the queue head,
  // at the expected cycle.
  logic [11:0] prev = 'x;
  always @(negedge clk) begin
    logic [11:0] obs;
    exp_t        e;
    obs = {periph_reset, core_reset, ready,
           lock_lost, lock_loss_count};
    n_cmp++;
    if ((!core_reset && periph_reset !== 1'b0) ||
        ready !== !core_reset) begin
      n_bad++;
      $display("FAIL invariant cyc=%0d got=%b", cyc, obs);
    end
    if (obs !== prev) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected cyc=%0d got=%b", cyc, obs);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || obs !== e.val) begin
          n_bad++;
          $display("FAIL event cyc=%0d got=%b want cyc=%0d %b",
                   cyc, obs, e.cyc, e.val);
        end
      end
      prev = obs;
    end else if (q.size() != 0 && cyc > q[0].cyc) begin
      n_cmp++;
      n_bad++;
      e = q.pop_front();
      $display("FAIL missed cyc=%0d got=%b want cyc=%0d %b",
               cyc, obs, e.cyc, e.val);
    end
  end

  task automatic push(int c, logic pr, logic cr, logic rd);
    exp_t e;
    e.cyc = c;
    e.val = {pr, cr, rd, m_ll, m_cnt};
    q.push_back(e);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic bringup();
    int e;
    pll_lock = 1'b1;
    e = cyc + 1;
    push(e + 10, 1'b0, 1'b1, 1'b0);
    push(e + 14, 1'b0, 1'b0, 1'b1);
    wait_cyc(e + 16);
  endtask

  task automatic lose();
    int e;
    pll_lock = 1'b0;
    e = cyc + 1;
    m_ll = 1'b1;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    push(e + 2, 1'b1, 1'b1, 1'b0);
    wait_cyc(e + 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int b;
    push(1, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bringup();

    // Short button glitch: filtered out.
    ext_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ext_rst_n = 1'b1;
    wait_cyc(cyc + 10);

    // Long press: ASSERT, then wait for debounced release.
    ext_rst_n = 1'b0;
    e = cyc + 1;
    push(e + 6, 1'b1, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    ext_rst_n = 1'b1;
    push(e + 20, 1'b0, 1'b1, 1'b0);
    push(e + 24, 1'b0, 1'b0, 1'b1);
    wait_cyc(e + 26);

    lose();
    bringup();

    // Lock chatter restarts the stable count.
    lose();
    pll_lock = 1'b1;
    e = cyc + 1;
    push(e + 16, 1'b0, 1'b1, 1'b0);
    push(e + 20, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    wait_cyc(e + 22);

    // Lock loss and button seen on the same FSM edge.
    ext_rst_n = 1'b0;
    b = cyc + 1;
    wait_cyc(b + 3);
    pll_lock = 1'b0;
    m_ll = 1'b1;
    m_cnt = m_cnt + 8'd1;
    push(b + 6, 1'b1, 1'b1, 1'b0);
    wait_cyc(b + 5);
    ext_rst_n = 1'b1;
    wait_cyc(b + 10);
    bringup();

    // Synchronous reset during RELEASE_PERIPH.
    lose();
    pll_lock = 1'b1;
    e = cyc + 1;
    push(e + 10, 1'b0, 1'b1, 1'b0);
    wait_cyc(e + 11);
    reset = 1'b1;
    m_ll = 1'b0;
    m_cnt = 8'd0;
    push(e + 12, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    push(e + 23, 1'b0, 1'b1, 1'b0);
    push(e + 27, 1'b0, 1'b0, 1'b1);
    wait_cyc(e + 29);

    // Saturation of the loss counter.
    for (int i = 0; i < 300; i++) begin
      lose();
      bringup();
    end

    wait_cyc(cyc + 5);
    n_cmp++;
    if (lock_loss_count !== 8'd255 || lock_lost !== 1'b1) begin
      n_bad++;
      $display("FAIL saturate got cnt=%0d lost=%b want 255 1",
               lock_loss_count, lock_lost);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
